// File: rtl/x_rr_arb32_pkg.sv
// Shared definitions for the 32-way round-robin arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package x_rr_arb32_pkg;

    localparam int N_REQ  = 32;
    localparam int ID_W   = 5;
    localparam int HCNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    function automatic logic [N_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
        return {{(N_REQ-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

// File: rtl/x_rr_arb32_if.sv
// Arbiter handshake bundle: request side in, grant side out.
// Latency: n/a (wiring only).
// Backpressure: none; owner signals completion with rel, ce freezes the arbiter.
// Signals: ce (clock enable), req[31:0], rel (owner release), gnt[31:0],
//          gnt_vld, gnt_id[4:0], any_req (combinational OR of req).
interface x_rr_arb32_if;
    import x_rr_arb32_pkg::*;

    logic             ce;
    logic [N_REQ-1:0] req;
    logic             rel;
    logic [N_REQ-1:0] gnt;
    logic             gnt_vld;
    logic [ID_W-1:0]  gnt_id;
    logic             any_req;

    modport master (output ce, req, rel, input gnt, gnt_vld, gnt_id, any_req);
    modport slave  (input ce, req, rel, output gnt, gnt_vld, gnt_id, any_req);
endinterface

// File: rtl/x_rr_pick32.sv
// Round-robin winner select: first set request after i_last, modulo 32.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_req[31:0] requests, i_last[4:0] last owner, o_win_id[4:0] winner,
//        o_any OR of all requests (o_win_id is don't-care when o_any is low).
import x_rr_arb32_pkg::*;

module x_rr_pick32 (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_last,
    output logic [ID_W-1:0]  o_win_id,
    output logic             o_any
);

    logic [ID_W:0]      w_sh;
    logic [N_REQ-1:0]   w_rot;
    logic [ID_W-1:0]    w_off;

    // Rotate so that index last+1 lands on bit 0; shift of 32 is legal
    // because the doubled vector keeps the wrapped copy.
    assign w_sh  = {1'b0, i_last} + 6'd1;
    assign w_rot = N_REQ'({i_req, i_req} >> w_sh);

    // Lowest set bit of the rotated vector is the nearest requester.
    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = ID_W'(i);
        end
    end

    // 5-bit addition wraps 31 -> 0 naturally.
    assign o_win_id = i_last + 5'd1 + w_off;
    assign o_any    = |i_req;

endmodule

// File: rtl/x_rr_arb32.sv
// Registered 32-way round-robin arbiter with hold limit and one-cycle turnaround gap.
// Latency: request to grant 1 cycle from idle; grant end clears gnt at the sampling edge.
// Backpressure: owner holds until req drop, rel or HOLD_MAX cycles; ce low freezes everything.
// Ports: i_clk, i_rst (async active-high), arb (slave side of x_rr_arb32_if).
import x_rr_arb32_pkg::*;

module x_rr_arb32 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    x_rr_arb32_if.slave  arb
);

    // Extra bit so a saturated counter (255) plus one never aliases a limit.
    localparam logic [HCNT_W:0] HOLD_LIM = (HCNT_W+1)'(HOLD_MAX);

    state_t             r_state,   w_state_nxt;
    logic [HCNT_W-1:0]  r_hcnt,    w_hcnt_nxt;
    logic [ID_W-1:0]    r_last,    w_last_nxt;
    logic [N_REQ-1:0]   r_gnt,     w_gnt_nxt;
    logic               r_gnt_vld, w_gnt_vld_nxt;
    logic [ID_W-1:0]    r_gnt_id,  w_gnt_id_nxt;

    logic [ID_W-1:0]    w_win_id;
    logic               w_any;
    logic               w_hold_hit;
    logic               w_take;

    x_rr_pick32 u_pick (
        .i_req    (arb.req),
        .i_last   (r_last),
        .o_win_id (w_win_id),
        .o_any    (w_any)
    );

    assign w_hold_hit = (HOLD_MAX != 0) &&
                        (({1'b0, r_hcnt} + (HCNT_W+1)'(1)) == HOLD_LIM);

    always_comb begin
        w_state_nxt   = r_state;
        w_hcnt_nxt    = r_hcnt;
        w_last_nxt    = r_last;
        w_gnt_nxt     = r_gnt;
        w_gnt_vld_nxt = r_gnt_vld;
        w_gnt_id_nxt  = r_gnt_id;
        w_take        = 1'b0;

        case (r_state)
            ST_IDLE: w_take = w_any;
            ST_GRANT: begin
                if (!arb.req[r_gnt_id] || arb.rel || w_hold_hit) begin
                    w_state_nxt   = ST_GAP;
                    w_gnt_nxt     = '0;
                    w_gnt_vld_nxt = 1'b0;
                    w_gnt_id_nxt  = '0;
                end else if (r_hcnt != '1) begin
                    w_hcnt_nxt = r_hcnt + 1'b1;
                end
            end
            ST_GAP: begin
                w_take      = w_any;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_take) begin
            w_state_nxt   = ST_GRANT;
            w_hcnt_nxt    = '0;
            w_last_nxt    = w_win_id;
            w_gnt_nxt     = id2onehot(w_win_id);
            w_gnt_vld_nxt = 1'b1;
            w_gnt_id_nxt  = w_win_id;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_hcnt    <= '0;
            r_last    <= ID_W'(N_REQ - 1);
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
            r_gnt_id  <= '0;
        end else if (arb.ce) begin
            r_state   <= w_state_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_last    <= w_last_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_vld <= w_gnt_vld_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
        end
    end

    assign arb.gnt     = r_gnt;
    assign arb.gnt_vld = r_gnt_vld;
    assign arb.gnt_id  = r_gnt_id;
    assign arb.any_req = w_any;

endmodule

// File: tb/tb_x_rr_arb32.sv
// Testbench for x_rr_arb32: four instances with different hold limits share stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_x_rr_arb32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce  = 1'b1;
    logic [31:0] req = '0;
    logic        rel = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    x_rr_arb32_if if_h16 ();
    x_rr_arb32_if if_h4  ();
    x_rr_arb32_if if_h0  ();
    x_rr_arb32_if if_h3  ();

    assign if_h16.ce = ce; assign if_h16.req = req; assign if_h16.rel = rel;
    assign if_h4.ce  = ce; assign if_h4.req  = req; assign if_h4.rel  = rel;
    assign if_h0.ce  = ce; assign if_h0.req  = req; assign if_h0.rel  = rel;
    assign if_h3.ce  = ce; assign if_h3.req  = req; assign if_h3.rel  = rel;

    x_rr_arb32 #(.HOLD_MAX(16)) u_h16 (.i_clk(clk), .i_rst(rst), .arb(if_h16));
    x_rr_arb32 #(.HOLD_MAX(4))  u_h4  (.i_clk(clk), .i_rst(rst), .arb(if_h4));
    x_rr_arb32 #(.HOLD_MAX(0))  u_h0  (.i_clk(clk), .i_rst(rst), .arb(if_h0));
    x_rr_arb32 #(.HOLD_MAX(3))  u_h3  (.i_clk(clk), .i_rst(rst), .arb(if_h3));

    logic [31:0] o_gnt [4];
    logic        o_vld [4];
    logic [4:0]  o_id  [4];
    logic        o_any [4];

    assign o_gnt[0] = if_h16.gnt; assign o_vld[0] = if_h16.gnt_vld; assign o_id[0] = if_h16.gnt_id; assign o_any[0] = if_h16.any_req;
    assign o_gnt[1] = if_h4.gnt;  assign o_vld[1] = if_h4.gnt_vld;  assign o_id[1] = if_h4.gnt_id;  assign o_any[1] = if_h4.any_req;
    assign o_gnt[2] = if_h0.gnt;  assign o_vld[2] = if_h0.gnt_vld;  assign o_id[2] = if_h0.gnt_id;  assign o_any[2] = if_h0.any_req;
    assign o_gnt[3] = if_h3.gnt;  assign o_vld[3] = if_h3.gnt_vld;  assign o_id[3] = if_h3.gnt_id;  assign o_any[3] = if_h3.any_req;

    // Reference model: owner index (-1 = none), gap flag, hold count, last owner.
    int hmax   [4] = '{16, 4, 0, 3};
    int m_own  [4];
    bit m_gap  [4];
    int m_hcnt [4];
    int m_last [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input int last, input logic [31:0] r);
        for (int k = 1; k <= 32; k++) begin
            if (r[(last + k) % 32]) return (last + k) % 32;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            m_own[d] = -1; m_gap[d] = 0; m_hcnt[d] = 0; m_last[d] = 31;
        end
    endtask

    task automatic model_grant(input int d, input int w);
        if (w >= 0) begin
            m_own[d] = w; m_last[d] = w; m_hcnt[d] = 0;
        end
    endtask

    task automatic model_edge();
        if (!ce) return;
        for (int d = 0; d < 4; d++) begin
            if (m_gap[d]) begin
                m_gap[d] = 0;
                model_grant(d, pick(m_last[d], req));
            end else if (m_own[d] >= 0) begin
                if (!req[m_own[d]] || rel || (hmax[d] != 0 && m_hcnt[d] + 1 == hmax[d])) begin
                    m_own[d] = -1;
                    m_gap[d] = 1;
                end else if (m_hcnt[d] < 255) begin
                    m_hcnt[d]++;
                end
            end else begin
                model_grant(d, pick(m_last[d], req));
            end
        end
    endtask

    task automatic check_outs();
        for (int d = 0; d < 4; d++) begin
            logic [31:0] eg;
            eg = (m_own[d] >= 0) ? (32'd1 << m_own[d]) : 32'd0;
            check($sformatf("gnt[h%0d]", hmax[d]), o_gnt[d], eg);
            check($sformatf("vld[h%0d]", hmax[d]), {31'd0, o_vld[d]}, {31'd0, m_own[d] >= 0});
            check($sformatf("id[h%0d]", hmax[d]), {27'd0, o_id[d]},
                  (m_own[d] >= 0) ? 32'(m_own[d]) : 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_outs();
    endtask

    task automatic set_req(input logic [31:0] r);
        req = r;
        #1;
        check("any_req", {31'd0, o_any[0]}, {31'd0, r != 0});
        check("any_req_h3", {31'd0, o_any[3]}, {31'd0, r != 0});
    endtask

    // Synchronous-looking reset pulse applied one step after an edge.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
    endtask

    // Observed owner of instance d, or all-ones when no grant.
    function automatic logic [31:0] own_of(input int d);
        return o_vld[d] ? {27'd0, o_id[d]} : 32'hFFFF_FFFF;
    endfunction

    int rp_seq [5]  = '{0, -1, 31, -1, 0};
    int fr_seq [11] = '{0, 0, 0, 0, -1, 1, 1, 1, 1, -1, 0};

    initial begin
        model_reset();
        #1;
        check_outs();
        step();
        rst = 1'b0;

        // Reset priority: index 0 first, then 31, alternating with gaps.
        do_reset();
        set_req(32'h8000_0001);
        rel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rp_seq", own_of(0), 32'(rp_seq[i]));
        end
        rel = 1'b0;

        // Wrap-around: LAST=30 with {2,31} requesting -> 31 then 2.
        do_reset();
        set_req(32'h4000_0000);
        step();
        check("wrap_30", own_of(0), 32'd30);
        set_req(32'h8000_0004);
        step();
        step();
        check("wrap_31", own_of(0), 32'd31);
        rel = 1'b1;
        step();
        rel = 1'b0;
        step();
        check("wrap_2", own_of(0), 32'd2);

        // Forced rotation between 0 and 1 on the HOLD_MAX=4 instance.
        do_reset();
        set_req(32'h0000_0003);
        for (int i = 0; i < 11; i++) begin
            step();
            check("fr_seq", own_of(1), 32'(fr_seq[i]));
        end

        // Unlimited hold: REQ[5] held 300 cycles on the HOLD_MAX=0 instance.
        do_reset();
        set_req(32'h0000_0020);
        for (int i = 0; i < 300; i++) begin
            step();
            check("h0_hold", o_gnt[2], 32'h0000_0020);
        end

        // Async reset between edges while 7 owns the grant.
        do_reset();
        set_req(32'h0000_0080);
        step();
        check("ar_own7", own_of(0), 32'd7);
        set_req(32'h0000_0081);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("ar_gnt_now", o_gnt[0], 32'd0);
        check("ar_vld_now", {31'd0, o_vld[0]}, 32'd0);
        check_outs();
        step();
        rst = 1'b0;
        step();
        check("ar_regrant0", own_of(0), 32'd0);

        // Clock-enable freeze mid-grant; ANY_REQ keeps following REQ.
        do_reset();
        set_req(32'h0000_0200);
        step();
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req((i % 2 == 0) ? 32'h0 : (32'h0000_0200 | $urandom));
            step();
            check("ce_frozen", o_gnt[3], 32'h0000_0200);
        end
        ce = 1'b1;
        set_req(32'h0000_0200);
        for (int i = 0; i < 6; i++) step();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r = r & $urandom & $urandom;
            if ($urandom_range(0, 9) == 0) r = '0;
            set_req(r);
            rel = ($urandom_range(0, 4) == 0);
            ce  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/x_rr_arb32.md
# x_rr_arb32

Registered 32-way round-robin arbiter sharing one downstream resource among 32 requesters. The 32-input OR reduction of the request vector is the arbiter's "any request" term and is also exported. The arbiter sequences ownership: it grants one requester, holds the grant until release or timeout, and inserts a one-cycle bus-turnaround gap. It then rotates priority.

## Interface
- HOLD_MAX, 16, maximum consecutive GRANT cycles per owner before forced rotation; 0 means unlimited; legal range 0..255.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous reset, active-high.
- CE  in  1  clock enable; when low, all state, counters and outputs hold.
- REQ  in  32  request vector, bit i from requester i; level-sensitive.
- RELEASE  in  1  current owner finished; sampled only in GRANT.
- GNT  out  32  registered one-hot grant, or all zero.
- GNT_VALID  out  1  registered; equals the OR of GNT.
- GNT_ID  out  5  registered index of the granted bit; 0 when GNT_VALID is low.
- ANY_REQ  out  1  combinational OR of REQ[31:0]; not registered.

## Operation
- States: IDLE, GRANT, GAP. Reset state is IDLE.
- Round-robin pointer LAST (5 bits) holds the last granted index. Reset value is 31, so index 0 has top priority first.
- Arbitration: the winner is the first set REQ bit scanning LAST+1, LAST+2, … modulo 32, wrapping 31→0. LAST updates to the winner on entry to GRANT.
- IDLE: ANY_REQ=1 at an edge → GRANT to the winner. Otherwise stay in IDLE.
- GRANT: hold counter HCNT (8 bits) clears on entry and increments each enabled cycle, saturating at 255. The grant ends at an edge where any of the following is true:
  - REQ[GNT_ID]=0;
  - RELEASE=1;
  - HOLD_MAX≠0 and HCNT+1 = HOLD_MAX.
- Grant end → GAP; GNT, GNT_VALID and GNT_ID clear.
- GAP lasts exactly one cycle. At its closing edge, ANY_REQ=1 → GRANT to the new winner; otherwise → IDLE.
- A forced-rotation owner that still requests is re-eligible, but only after all other active requesters in the scan order.
- Single requester with continuous REQ and HOLD_MAX=N: grant N cycles, gap 1 cycle, grant N cycles, and so on.
- Simultaneous REQ drop and RELEASE: treated as a single grant end.
- New REQ bits asserted during GRANT: no effect until the next arbitration.
- CE=0: the state machine, HCNT and LAST freeze and outputs hold. ANY_REQ still follows REQ.
- RST asserted in any state, including mid-grant: GNT=0, GNT_VALID=0, GNT_ID=0, LAST=31, HCNT=0, state=IDLE, all immediately without waiting for a clock edge.
- RST deassertion: first arbitration at the first enabled edge after release.

## Timing
- Reset values: GNT=32'h0, GNT_VALID=0, GNT_ID=5'd0. ANY_REQ reflects REQ during reset.
- Request-to-grant latency from IDLE: REQ sampled at edge k, GNT visible after edge k (one cycle).
- Grant-end latency: the condition is sampled at edge k; GNT is low after edge k.
- Handover: the next GNT is visible after edge k+1, so exactly one zero-grant cycle separates owners.
- Maximum GNT high time: HOLD_MAX cycles.
- No combinational path from REQ or RELEASE to GNT, GNT_VALID or GNT_ID.

## Structure
- Shared package/include: state encodings (IDLE=2'b00, GRANT=2'b01, GAP=2'b10), width constants N_REQ=32 and ID_W=5, and the HCNT width.
- One natural sub-module, x_rr_pick32. It is purely combinational: it takes REQ[31:0] and LAST[4:0] and produces WIN_ID[4:0] and ANY. It implements a rotate, a priority encode, and a 32-input OR reduction.
- The top level holds the state machine, HCNT, LAST and the output registers.

## Test plan
- Reset priority: RST pulse, then REQ=32'h8000_0001 held, RELEASE pulsed one cycle after each grant → grants alternate: GNT_ID 0, gap, 31, gap, 0.
- Wrap-around: LAST=30, REQ bits {2,31} set → next GNT_ID=31; after it ends → GNT_ID=2.
- Forced rotation: HOLD_MAX=4, REQ=32'h0000_0003 held with no RELEASE → GNT_ID=0 for exactly 4 cycles, 1 gap cycle, GNT_ID=1 for 4 cycles, 1 gap cycle, back to 0.
- HOLD_MAX=0 with REQ[5] held for 300 cycles → GNT[5] stays high throughout; HCNT saturates and causes no drop.
- Async reset mid-grant: GNT_ID=7 active, RST asserted between edges → GNT=0 and GNT_VALID=0 before the next edge. After release with REQ[7] still set → next grant is index 0 if REQ[0] is set, else 7.
- CE gating and ANY_REQ: CE=0 during GRANT for 5 cycles with HOLD_MAX=3 → GNT is unchanged and HCNT is frozen. REQ toggles during the freeze → ANY_REQ follows combinationally.
